// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock timekeeping blocks: mode encodings
// and BCD field limits. Hours are held as {tens[1:0], ones[3:0]}.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_MIN = 2'b01,
        MODE_SET_HR  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;

    localparam logic [5:0] HR24_RESET = 6'h00;
    localparam logic [5:0] HR24_MAX   = 6'h23;

    localparam logic [5:0] HR12_RESET = 6'h12;
    localparam logic [5:0] HR12_MAX   = 6'h12;
    localparam logic [5:0] HR12_MIN   = 6'h01;
    localparam logic [5:0] HR12_PM_TOGGLE = 6'h11;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..LIMIT with synchronous clear; co flags the step
// that wraps LIMIT back to 00 so the next field can advance on the same edge.
module bcd_mod60
    import clock_pkg::*;
#(
    parameter logic [7:0] LIMIT = SEC_MAX
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] ones,
    output logic [2:0] tens,
    output logic       co
);

    logic at_limit;

    assign at_limit = ({1'b0, tens, ones} == LIMIT);
    assign co       = en & at_limit;

    always_ff @(posedge clk) begin
        if (clr) begin
            ones <= 4'd0;
            tens <= 3'd0;
        end else if (en) begin
            if (at_limit) begin
                ones <= 4'd0;
                tens <= 3'd0;
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 3'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss timekeeper driven by the 1 Hz tick, with 12/24 h formats,
// manual minute/hour setting and a day (or half-day) rollover pulse.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int HOURS = 24
) (
    input  logic       CLK,
    input  logic       CLEAR,
    input  logic       TICK,
    input  logic [1:0] SET_MODE,
    input  logic       INC,
    output logic [3:0] SEC_ONES,
    output logic [2:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic [2:0] MIN_TENS,
    output logic [3:0] HR_ONES,
    output logic [1:0] HR_TENS,
    output logic       PM,
    output logic       ROLLOVER
);

    if (HOURS != 12 && HOURS != 24) begin : g_bad_hours
        $error("bcd_time_counter: HOURS must be 12 or 24, got %0d", HOURS);
    end

    localparam bit         IS12       = (HOURS == 12);
    localparam logic [5:0] HR_RESET   = IS12 ? HR12_RESET : HR24_RESET;
    localparam logic [5:0] HR_MAX     = IS12 ? HR12_MAX   : HR24_MAX;
    localparam logic [5:0] HR_WRAP_TO = IS12 ? HR12_MIN   : HR24_RESET;
    // The hour whose increment ends the day (24 h) or half-day (12 h)
    localparam logic [5:0] HR_DAY_END = IS12 ? HR12_PM_TOGGLE : HR24_MAX;

    mode_e      mode;
    logic       run, set_min, set_hr;
    logic       sec_co, min_co, hr_step;
    logic [5:0] hr_q, hr_inc, hr_next;
    logic       pm_flip, day_wrap;

    assign mode    = mode_e'(SET_MODE);
    assign set_min = (mode == MODE_SET_MIN);
    assign set_hr  = (mode == MODE_SET_HR);
    assign run     = ~(set_min | set_hr);

    // Seconds are held at 00 for as long as either set mode is active
    bcd_mod60 #(.LIMIT(SEC_MAX)) u_sec (
        .clk  (CLK),
        .clr  (CLEAR | set_min | set_hr),
        .en   (run & TICK),
        .ones (SEC_ONES),
        .tens (SEC_TENS),
        .co   (sec_co)
    );

    bcd_mod60 #(.LIMIT(MIN_MAX)) u_min (
        .clk  (CLK),
        .clr  (CLEAR),
        .en   ((run & sec_co) | (set_min & INC)),
        .ones (MIN_ONES),
        .tens (MIN_TENS),
        .co   (min_co)
    );

    // Minute carry only reaches the hours while running; set mode never carries
    assign hr_step = (run & min_co) | (set_hr & INC);

    always_comb begin
        hr_inc   = (hr_q[3:0] == 4'd9) ? {hr_q[5:4] + 2'd1, 4'd0}
                                       : {hr_q[5:4], hr_q[3:0] + 4'd1};
        hr_next  = (hr_q == HR_MAX) ? HR_WRAP_TO : hr_inc;
        pm_flip  = IS12 && (hr_q == HR12_PM_TOGGLE);
        day_wrap = (hr_q == HR_DAY_END);
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            hr_q     <= HR_RESET;
            PM       <= 1'b0;
            ROLLOVER <= 1'b0;
        end else begin
            ROLLOVER <= run & min_co & day_wrap;
            if (hr_step) begin
                hr_q <= hr_next;
                if (pm_flip) begin
                    PM <= ~PM;
                end
            end
        end
    end

    assign HR_TENS = hr_q[5:4];
    assign HR_ONES = hr_q[3:0];

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed-vector bench for bcd_time_counter: a 24 h and a 12 h instance share
// the stimulus; expected times are queued by the driver and checked by a monitor.
module tb_bcd_time_counter;

    localparam logic [1:0] RUN  = 2'b00;
    localparam logic [1:0] SMIN = 2'b01;
    localparam logic [1:0] SHR  = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    typedef struct packed {
        logic       sel12;
        logic [1:0] ht;
        logic [3:0] ho;
        logic [2:0] mt;
        logic [3:0] mo;
        logic [2:0] st;
        logic [3:0] so;
        logic       pm;
        logic       roll;
    } exp_t;

    logic       CLK = 1'b0;
    logic       CLEAR = 1'b0;
    logic       TICK = 1'b0;
    logic [1:0] SET_MODE = 2'b00;
    logic       INC = 1'b0;
    logic       chk = 1'b0;

    logic [3:0] a_so, b_so, a_mo, b_mo, a_ho, b_ho;
    logic [2:0] a_st, b_st, a_mt, b_mt;
    logic [1:0] a_ht, b_ht;
    logic       a_pm, b_pm, a_roll, b_roll;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 CLK = ~CLK;

    bcd_time_counter #(.HOURS(24)) u24 (
        .CLK(CLK), .CLEAR(CLEAR), .TICK(TICK), .SET_MODE(SET_MODE), .INC(INC),
        .SEC_ONES(a_so), .SEC_TENS(a_st), .MIN_ONES(a_mo), .MIN_TENS(a_mt),
        .HR_ONES(a_ho), .HR_TENS(a_ht), .PM(a_pm), .ROLLOVER(a_roll)
    );

    bcd_time_counter #(.HOURS(12)) u12 (
        .CLK(CLK), .CLEAR(CLEAR), .TICK(TICK), .SET_MODE(SET_MODE), .INC(INC),
        .SEC_ONES(b_so), .SEC_TENS(b_st), .MIN_ONES(b_mo), .MIN_TENS(b_mt),
        .HR_ONES(b_ho), .HR_TENS(b_ht), .PM(b_pm), .ROLLOVER(b_roll)
    );

    task automatic step(input logic c, input logic t, input logic [1:0] m, input logic i);
        @(negedge CLK);
        CLEAR = c; TICK = t; SET_MODE = m; INC = i; chk = 1'b0;
    endtask

    task automatic step_chk(input logic c, input logic t, input logic [1:0] m, input logic i,
                            input string nm, input logic s12, input logic [7:0] hr,
                            input logic [7:0] mn, input logic [7:0] sc,
                            input logic pm, input logic roll);
        exp_t e;
        @(negedge CLK);
        CLEAR = c; TICK = t; SET_MODE = m; INC = i; chk = 1'b1;
        e.sel12 = s12;
        e.ht = hr[5:4]; e.ho = hr[3:0];
        e.mt = mn[6:4]; e.mo = mn[3:0];
        e.st = sc[6:4]; e.so = sc[3:0];
        e.pm = pm; e.roll = roll;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, RUN, 1'b0);
    endtask

    task automatic incs(input logic [1:0] m, input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, m, 1'b1);
    endtask

    // Monitor: compares the selected instance one step after each checked edge
    always @(posedge CLK) begin
        exp_t  e;
        exp_t  act;
        string nm;
        #1;
        if (chk) begin
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: check requested with no expected entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act.sel12 = e.sel12;
                if (e.sel12)
                    {act.ht, act.ho, act.mt, act.mo, act.st, act.so, act.pm, act.roll} =
                        {b_ht, b_ho, b_mt, b_mo, b_st, b_so, b_pm, b_roll};
                else
                    {act.ht, act.ho, act.mt, act.mo, act.st, act.so, act.pm, act.roll} =
                        {a_ht, a_ho, a_mt, a_mo, a_st, a_so, a_pm, a_roll};
                n_vec++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h:%h:%h pm=%b roll=%b, expected %h:%h:%h pm=%b roll=%b",
                             nm, {act.ht, act.ho}, {act.mt, act.mo}, {act.st, act.so}, act.pm, act.roll,
                             {e.ht, e.ho}, {e.mt, e.mo}, {e.st, e.so}, e.pm, e.roll);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values, both formats
        step_chk(1, 0, RUN, 0, "reset24", 0, 8'h00, 8'h00, 8'h00, 0, 0);
        step_chk(1, 0, RUN, 0, "reset12", 1, 8'h12, 8'h00, 8'h00, 0, 0);

        // Seconds up to 58, then carry into minutes with back-to-back ticks
        ticks(57);
        step_chk(0, 1, RUN, 0, "sec58", 0, 8'h00, 8'h00, 8'h58, 0, 0);
        step_chk(0, 1, RUN, 0, "sec59", 0, 8'h00, 8'h00, 8'h59, 0, 0);
        step_chk(0, 1, RUN, 0, "min_carry", 0, 8'h00, 8'h01, 8'h00, 0, 0);
        step_chk(0, 0, RUN, 0, "idle_hold", 0, 8'h00, 8'h01, 8'h00, 0, 0);
        step_chk(0, 1, RUN, 1, "run_tick_inc", 0, 8'h00, 8'h01, 8'h01, 0, 0);
        step_chk(0, 1, RSVD, 1, "mode11_runs", 0, 8'h00, 8'h01, 8'h02, 0, 0);

        // Build 10:59:37 through set mode and run
        step_chk(0, 0, SHR, 1, "sethr_first", 0, 8'h01, 8'h01, 8'h00, 0, 0);
        incs(SHR, 9);
        incs(SMIN, 58);
        ticks(36);
        step_chk(0, 1, RUN, 0, "at_105937", 0, 8'h10, 8'h59, 8'h37, 0, 0);
        step_chk(0, 0, SMIN, 0, "set_clears_sec", 0, 8'h10, 8'h59, 8'h00, 0, 0);
        step_chk(0, 0, SMIN, 1, "min_wrap_nocarry", 0, 8'h10, 8'h00, 8'h00, 0, 0);
        step_chk(0, 1, SMIN, 0, "tick_in_setmin", 0, 8'h10, 8'h00, 8'h00, 0, 0);
        step_chk(0, 1, SMIN, 1, "setmin_tick_inc", 0, 8'h10, 8'h01, 8'h00, 0, 0);
        step_chk(0, 1, SHR, 0, "tick_in_sethr", 0, 8'h10, 8'h01, 8'h00, 0, 0);

        // Hours 22 -> 23 -> 00 -> 01 in set mode, no rollover
        incs(SHR, 12);
        step_chk(0, 0, SHR, 1, "sethr_23", 0, 8'h23, 8'h01, 8'h00, 0, 0);
        step_chk(0, 0, SHR, 1, "sethr_00", 0, 8'h00, 8'h01, 8'h00, 0, 0);
        step_chk(0, 0, SHR, 1, "sethr_01", 0, 8'h01, 8'h01, 8'h00, 0, 0);
        step_chk(0, 1, RUN, 0, "resume_run", 0, 8'h01, 8'h01, 8'h01, 0, 0);
        step_chk(1, 1, SHR, 1, "clear_in_set", 0, 8'h00, 8'h00, 8'h00, 0, 0);

        // 24 h day wrap
        incs(SHR, 23);
        incs(SMIN, 59);
        ticks(58);
        step_chk(0, 1, RUN, 0, "at_235959", 0, 8'h23, 8'h59, 8'h59, 0, 0);
        step_chk(0, 1, RUN, 0, "day_wrap", 0, 8'h00, 8'h00, 8'h00, 0, 1);
        step_chk(0, 0, RUN, 0, "roll_one_cycle", 0, 8'h00, 8'h00, 8'h00, 0, 0);

        // 12 h format: noon and 12 -> 1 o'clock
        step_chk(1, 0, RUN, 0, "reset12_again", 1, 8'h12, 8'h00, 8'h00, 0, 0);
        step_chk(0, 0, SHR, 1, "set12_wrap_01", 1, 8'h01, 8'h00, 8'h00, 0, 0);
        incs(SHR, 10);
        incs(SMIN, 59);
        ticks(58);
        step_chk(0, 1, RUN, 0, "at_115959", 1, 8'h11, 8'h59, 8'h59, 0, 0);
        step_chk(0, 1, RUN, 0, "noon_roll", 1, 8'h12, 8'h00, 8'h00, 1, 1);
        step_chk(0, 1, RUN, 0, "after_noon", 1, 8'h12, 8'h00, 8'h01, 1, 0);
        incs(SMIN, 59);
        ticks(58);
        step_chk(0, 1, RUN, 0, "at_125959", 1, 8'h12, 8'h59, 8'h59, 1, 0);
        step_chk(0, 1, RUN, 0, "one_pm", 1, 8'h01, 8'h00, 8'h00, 1, 0);
        incs(SHR, 10);
        step_chk(0, 0, SHR, 1, "set_pm_toggle", 1, 8'h12, 8'h00, 8'h00, 0, 0);

        step(0, 0, RUN, 0);
        step(0, 0, RUN, 0);
        @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Downstream consumer of the clock-divider chain in the digital clock. Takes the one-cycle 1 Hz enable pulse produced by the last divider stage and keeps time as BCD hours:minutes:seconds for the display decoders. Supports 24-hour or 12-hour (with PM flag) counting and a manual set mode that steps minutes or hours. Emits a day-rollover pulse.

## Interface
- `HOURS`, default 24: hour format. Legal values are 24 (00–23) or 12 (01–12 with PM). Any other value is illegal and must be flagged by an elaboration-time check.
- `CLK` in 1: system clock. All state is updated on the rising edge.
- `CLEAR` in 1: synchronous, active-high reset.
- `TICK` in 1: 1-second enable. Exactly one `CLK` cycle high. This is the divider `OUT`, launched on the falling edge and sampled here on the rising edge.
- `SET_MODE` in 2: 00 = run, 01 = set minutes, 10 = set hours, 11 = treated as run.
- `INC` in 1: one-cycle pulse. Steps the selected field in set mode.
- `SEC_ONES` out 4, `SEC_TENS` out 3: BCD seconds.
- `MIN_ONES` out 4, `MIN_TENS` out 3: BCD minutes.
- `HR_ONES` out 4, `HR_TENS` out 2: BCD hours.
- `PM` out 1: afternoon flag. Held at 0 when `HOURS`=24.
- `ROLLOVER` out 1: one-cycle pulse on the day/half-day wrap.

## Operation
- **Reset:** `CLEAR`=1 at a rising edge has priority over everything else.
  - Seconds and minutes go to 00.
  - Hours go to 00 (24 h) or 12 (12 h).
  - `PM`=0 and `ROLLOVER`=0.
  - Reset mid-operation, including during set mode, behaves identically.
- **Run mode:**
  - When `TICK`=1, seconds advance by 1 in BCD. Ones digit wraps 9→0 and carries to tens; seconds 59→00 carries to minutes.
  - Minutes 59→00 carries to hours.
  - Hours (24 h): 23→00, asserting `ROLLOVER`.
  - Hours (12 h): 12→01, and 11→12 toggles `PM`. `ROLLOVER` asserts on the 11:59:59→12:00:00 step.
  - `INC` is ignored.
- **Set mode (01/10):**
  - `TICK` is ignored.
  - Seconds are forced to 00 on every cycle in which set mode is active.
  - When `INC`=1, the selected field increments with wrap and no carry into the neighbouring field:
    - minutes 59→00;
    - hours 23→00 (24 h) or 12→01 (12 h);
    - in 12 h, hours 11→12 toggles `PM`.
  - `ROLLOVER` is never asserted in set mode.
- **Mode change:** takes effect the same cycle `SET_MODE` is sampled. Switching from set back to run resumes counting from xx:yy:00 on the next `TICK`.
- **Simultaneous `TICK` and `INC`:** only the event belonging to the current mode acts.
- **Arithmetic:** all digit compares are on BCD values, never binary. Fields never hold a non-BCD or out-of-range value.

## Timing
- All outputs are registered.
- `TICK` or `INC` sampled at edge n changes the outputs right after edge n, i.e. latency 1.
- `ROLLOVER` is high for exactly the one cycle following the wrapping edge, coincident with the wrapped time value.
- Back-to-back `TICK` on consecutive cycles must each advance 1 s. No minimum spacing is assumed.
- The full carry chain (seconds→minutes→hours→`PM`/`ROLLOVER`) completes in a single edge.

## Structure
- **Shared package `clock_pkg`:**
  - `SET_MODE` encodings (`MODE_RUN`, `MODE_SET_MIN`, `MODE_SET_HR`);
  - BCD limits (`SEC_MAX`=59, `MIN_MAX`=59);
  - hour reset/limit constants for 12 h and 24 h.
- **Sub-module `bcd_mod60`:** two-digit BCD counter with `en`, synchronous `clr`, and carry-out on 59→00. Instantiated twice, for seconds and minutes.
- **Hours:** the hour/`PM`/`ROLLOVER` logic and the mode decode stay in the top.

## Test plan
- **Reset value:** `CLEAR` pulse → 00:00:00 (24 h) or 12:00:00 with `PM`=0 (12 h); `ROLLOVER`=0.
- **Minute carry:** start at 00:00:58, apply two `TICK`s → 00:00:59, then 00:01:00.
- **Day wrap (24 h):** at 23:59:59, one `TICK` → 00:00:00, with `ROLLOVER` high for exactly 1 cycle.
- **12 h wraps:** at 11:59:59 `PM`=0, one `TICK` → 12:00:00 `PM`=1 with `ROLLOVER` pulse. Continue from 12:59:59 → 01:00:00 with `PM` still 1.
- **Set mode:**
  - `SET_MODE`=01 from 10:59:37 → seconds read 00 next cycle; `INC` → 10:00:00, with no hour carry.
  - `SET_MODE`=10 with 3 `INC` from 22 (24 h) → 23, 00, 01.
  - `TICK`s during set mode change nothing.
- **Simultaneous events:** `TICK`+`INC` in run mode advance seconds only. `CLEAR` asserted together with `TICK` during set mode gives the reset values.
